// File: rtl/lsu_pkg.sv
// lsu_pkg: encodings, FSM states and lane helper functions for lsu_mc
package lsu_pkg;
  localparam logic [2:0] LD_LW = 3'b000, LD_LH = 3'b001, LD_LB = 3'b010, LD_LHU = 3'b011, LD_LBU = 3'b100;
  localparam logic [1:0] ST_NONE = 2'b00, ST_SW = 2'b01, ST_SH = 2'b10, ST_SB = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
  function automatic logic [3:0] base_mask(input logic [1:0] sz);
    return sz == ST_SW ? 4'b1111 : sz == ST_SH ? 4'b0011 : 4'b0001;
  endfunction
  function automatic logic [31:0] extend(input logic [2:0] ld, input logic [31:0] d);
    return ld == LD_LH  ? {{16{d[15]}}, d[15:0]} :
           ld == LD_LB  ? {{24{d[7]}}, d[7:0]} :
           ld == LD_LHU ? {16'b0, d[15:0]} :
           ld == LD_LBU ? {24'b0, d[7:0]} : d;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-lane mask/data shift and two-beat load merge/extend
module lsu_lane_align import lsu_pkg::*; (
  input  logic [1:0]  off,
  input  logic [1:0]  sz,
  input  logic [2:0]  ld,
  input  logic [31:0] wdata,
  input  logic [31:0] beat1,
  input  logic [31:0] beat2,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata
);
  logic [31:0] merged;
  assign mask = {4'b0, base_mask(sz)} << off;
  assign wdata_sh = {32'b0, wdata} << {off, 3'b000};
  assign merged = 32'({beat2, beat1} >> {off, 3'b000});
  assign rdata = extend(ld, merged);
endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit on a req/gnt/rvalid bus; define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats
module lsu_mc import lsu_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int RD_ADDR_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [2:0]           ld_cntr_i,
  input  logic [1:0]           st_cntr_i,
  input  logic [31:0]          wdata_i,
  input  logic [RD_ADDR_W-1:0] rd_addr_i,
  output logic                 dmem_req,
  input  logic                 dmem_gnt,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_rvalid,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_err,
  output logic                 done_o,
  output logic                 reg_write_o,
  output logic [RD_ADDR_W-1:0] rd_addr_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 misalign_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] ld_q;
  logic [1:0] sz_q, sz;
  logic [31:0] wdata_q, buf1, buf2, ld_data;
  logic [RD_ADDR_W-1:0] rd_q;
  logic [TW-1:0] tcnt;
  logic [7:0] mask8;
  logic [63:0] wdata64;
  logic we_q, err_q, mis_q, beat, two;
  logic accept, is_st, word, half, mis, ill, skip, to_hit;
  assign accept = lsu_valid_i && state == S_IDLE;
  assign is_st = st_cntr_i != ST_NONE;
  assign word = is_st ? st_cntr_i == ST_SW : ld_cntr_i == LD_LW;
  assign half = is_st ? st_cntr_i == ST_SH : ld_cntr_i == LD_LH || ld_cntr_i == LD_LHU;
  assign sz = is_st ? st_cntr_i : word ? ST_SW : half ? ST_SH : ST_SB;
  assign mis = word && addr_i[1:0] != 2'b00 || half && addr_i[1:0] == 2'b11;
  assign ill = !is_st && ld_cntr_i > LD_LBU;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
  logic beat_q, two_q;
  always_ff @(posedge clk)
    if (rst) {beat_q, two_q} <= 2'b00;
    else if (accept) {beat_q, two_q} <= {1'b0, mis};
    else if (state == S_RESP && dmem_rvalid && two_q) beat_q <= 1'b1;
  assign beat = beat_q;
  assign two = two_q;
`else
  localparam bit SPLIT = 1'b0;
  assign beat = 1'b0;
  assign two = 1'b0;
`endif
  assign skip = ill || mis && !SPLIT;
  assign to_hit = TIMEOUT_CYC != 0 && int'(tcnt) + 1 == TIMEOUT_CYC &&
                  (state == S_REQ && !dmem_gnt || state == S_RESP && !dmem_rvalid);
  lsu_lane_align u_align (
    .off(addr_q[1:0]), .sz(sz_q), .ld(ld_q), .wdata(wdata_q), .beat1(buf1), .beat2(buf2),
    .mask(mask8), .wdata_sh(wdata64), .rdata(ld_data)
  );
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = accept ? (skip ? S_DONE : S_REQ) : S_IDLE;
      S_REQ:   state_n = dmem_gnt ? S_RESP : to_hit ? S_DONE : S_REQ;
      S_RESP:  state_n = dmem_rvalid ? (two && !beat ? S_REQ : S_DONE) : to_hit ? S_DONE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst || state_n != state || dmem_gnt || dmem_rvalid) tcnt <= '0;
    else if (state == S_REQ || state == S_RESP) tcnt <= tcnt + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      {addr_q, ld_q, sz_q, wdata_q, rd_q, we_q, err_q, mis_q, buf1, buf2} <= '0;
    end else if (accept) begin
      {addr_q, ld_q, sz_q, wdata_q, rd_q, we_q} <= {addr_i, ld_cntr_i, sz, wdata_i, rd_addr_i, is_st};
      err_q <= skip;
      mis_q <= mis;
    end else if (state == S_RESP && dmem_rvalid) begin
      buf1 <= beat ? buf1 : dmem_rdata;
      buf2 <= beat ? dmem_rdata : buf2;
      err_q <= err_q | dmem_err;
    end else if (to_hit) begin
      err_q <= 1'b1;
    end
  assign lsu_ready_o = state == S_IDLE;
  assign dmem_req = state == S_REQ;
  assign dmem_addr = dmem_req ? {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(beat), 2'b00} : '0;
  assign dmem_we = dmem_req && we_q;
  assign dmem_be = dmem_req ? (beat ? mask8[7:4] : mask8[3:0]) : 4'b0;
  assign dmem_wdata = dmem_we ? (beat ? wdata64[63:32] : wdata64[31:0]) : 32'b0;
  assign done_o = state == S_DONE;
  assign reg_write_o = done_o && !we_q && !err_q;
  assign rd_addr_o = done_o ? rd_q : '0;
  assign rdata_o = reg_write_o ? ld_data : 32'b0;
  assign err_o = done_o && err_q;
  assign misalign_o = done_o && mis_q;
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: directed self-checking bench for lsu_mc with a cycle-level bus responder
module tb_lsu_mc;
  logic clk = 1'b0, rst = 1'b1;
  logic lsu_valid_i = 1'b0, lsu_ready_o;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [2:0] ld_cntr_i = '0;
  logic [1:0] st_cntr_i = '0;
  logic [4:0] rd_addr_i = '0, rd_addr_o;
  logic dmem_req, dmem_gnt = 1'b0, dmem_we, dmem_rvalid = 1'b0, dmem_err = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, rdata_o;
  logic [3:0] dmem_be;
  logic done_o, reg_write_o, err_o, misalign_o;
  int n_chk = 0, n_err = 0, req_cyc, n_gnt, cyc;
  logic [31:0] g_addr [2], g_wd [2];
  logic [3:0] g_be [2];
  logic g_we;
  always #5 clk = ~clk;
  lsu_mc #(.ADDR_W(32), .TIMEOUT_CYC(4), .RD_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .addr_i(addr_i), .ld_cntr_i(ld_cntr_i), .st_cntr_i(st_cntr_i), .wdata_i(wdata_i),
    .rd_addr_i(rd_addr_i), .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .done_o(done_o), .reg_write_o(reg_write_o),
    .rd_addr_o(rd_addr_o), .rdata_o(rdata_o), .err_o(err_o), .misalign_o(misalign_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    tick();
    check({tag, "_ready"}, lsu_ready_o, 1'b1);
    check({tag, "_done_clr"}, done_o, 1'b0);
  endtask
  task automatic run(input logic [31:0] a, input logic [2:0] ld, input logic [1:0] st,
                     input logic [31:0] wd, input int gd, input logic [31:0] r1,
                     input logic [31:0] r2, input logic e);
    int w = 0;
    req_cyc = 0; n_gnt = 0; cyc = 0;
    g_addr[0] = 'x; g_addr[1] = 'x; g_be[0] = 'x; g_be[1] = 'x; g_wd[0] = 'x; g_wd[1] = 'x; g_we = 1'bx;
    lsu_valid_i = 1'b1; addr_i = a; ld_cntr_i = ld; st_cntr_i = st; wdata_i = wd; rd_addr_i = 5'd13;
    tick();
    lsu_valid_i = 1'b0;
    while (!done_o && cyc < 40) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
      if (dmem_req) begin
        req_cyc++;
        if (w == gd) begin
          dmem_gnt = 1'b1;
          if (n_gnt < 2) begin
            g_addr[n_gnt] = dmem_addr; g_be[n_gnt] = dmem_be; g_wd[n_gnt] = dmem_wdata;
          end
          g_we = dmem_we;
          n_gnt++;
          w = 0;
        end else w++;
      end else if (!lsu_ready_o) begin
        dmem_rvalid = 1'b1; dmem_rdata = n_gnt > 1 ? r2 : r1; dmem_err = e;
      end
      cyc++;
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
    check("done_seen", done_o, 1'b1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ready", lsu_ready_o, 1'b1);
    check("rst_req", dmem_req, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    tick();
    run(32'h100, 3'b000, 2'b00, 32'h0, 0, 32'hDEADBEEF, 32'h0, 1'b0);
    check("lw_latency", cyc, 2);
    check("lw_addr", g_addr[0], 32'h100);
    check("lw_be", g_be[0], 4'b1111);
    check("lw_we", g_we, 1'b0);
    check("lw_rdata", rdata_o, 32'hDEADBEEF);
    check("lw_rw", reg_write_o, 1'b1);
    check("lw_rd", rd_addr_o, 5'd13);
    check("lw_err", err_o, 1'b0);
    check("lw_mis", misalign_o, 1'b0);
    idle_chk("lw");
    run(32'h203, 3'b000, 2'b11, 32'h000000A5, 2, 32'h0, 32'h0, 1'b0);
    check("sb_req_cyc", req_cyc, 3);
    check("sb_addr", g_addr[0], 32'h200);
    check("sb_be", g_be[0], 4'b1000);
    check("sb_wdata", g_wd[0], 32'hA5000000);
    check("sb_we", g_we, 1'b1);
    check("sb_rw", reg_write_o, 1'b0);
    check("sb_err", err_o, 1'b0);
    idle_chk("sb");
    run(32'h102, 3'b000, 2'b10, 32'hFFFF1234, 0, 32'h0, 32'h0, 1'b0);
    check("sh_be", g_be[0], 4'b1100);
    check("sh_wdata", g_wd[0], 32'h12340000);
    idle_chk("sh");
    run(32'h106, 3'b001, 2'b00, 32'h0, 0, 32'h80F01234, 32'h0, 1'b0);
    check("lh_be", g_be[0], 4'b1100);
    check("lh_rdata", rdata_o, 32'hFFFF80F0);
    idle_chk("lh");
    run(32'h106, 3'b011, 2'b00, 32'h0, 1, 32'h80F01234, 32'h0, 1'b0);
    check("lhu_rdata", rdata_o, 32'h000080F0);
    idle_chk("lhu");
    run(32'h101, 3'b010, 2'b00, 32'h0, 0, 32'h00008000, 32'h0, 1'b0);
    check("lb_be", g_be[0], 4'b0010);
    check("lb_rdata", rdata_o, 32'hFFFFFF80);
    idle_chk("lb");
    run(32'h102, 3'b100, 2'b00, 32'h0, 0, 32'h807F0000, 32'h0, 1'b0);
    check("lbu_rdata", rdata_o, 32'h0000007F);
    idle_chk("lbu");
    run(32'h103, 3'b000, 2'b00, 32'h0, 0, 32'h11AABBCC, 32'h00332211, 1'b0);
    check("mis_flag", misalign_o, 1'b1);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("split_ngnt", n_gnt, 2);
    check("split_addr0", g_addr[0], 32'h100);
    check("split_addr1", g_addr[1], 32'h104);
    check("split_be0", g_be[0], 4'b1000);
    check("split_be1", g_be[1], 4'b0111);
    check("split_rdata", rdata_o, 32'h33221111);
    check("split_err", err_o, 1'b0);
    check("split_rw", reg_write_o, 1'b1);
`else
    check("mis_noreq", req_cyc, 0);
    check("mis_err", err_o, 1'b1);
    check("mis_rw", reg_write_o, 1'b0);
    check("mis_rdata", rdata_o, 32'h0);
`endif
    idle_chk("mis");
    run(32'h100, 3'b101, 2'b00, 32'h0, 0, 32'h0, 32'h0, 1'b0);
    check("ill_noreq", req_cyc, 0);
    check("ill_err", err_o, 1'b1);
    check("ill_rw", reg_write_o, 1'b0);
    idle_chk("ill");
    run(32'h108, 3'b000, 2'b00, 32'h0, 0, 32'h12345678, 32'h0, 1'b1);
    check("berr_err", err_o, 1'b1);
    check("berr_rdata", rdata_o, 32'h0);
    check("berr_rw", reg_write_o, 1'b0);
    idle_chk("berr");
    run(32'h10C, 3'b000, 2'b00, 32'h0, -1, 32'h0, 32'h0, 1'b0);
    check("to_req_cyc", req_cyc, 4);
    check("to_err", err_o, 1'b1);
    check("to_rw", reg_write_o, 1'b0);
    check("to_req_drop", dmem_req, 1'b0);
    idle_chk("to");
    lsu_valid_i = 1'b1; addr_i = 32'h100; ld_cntr_i = 3'b000; st_cntr_i = 2'b00;
    tick();
    lsu_valid_i = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rstm_in_resp", lsu_ready_o, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_req", dmem_req, 1'b0);
    check("rstm_ready", lsu_ready_o, 1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    check("rstm_late_done", done_o, 1'b0);
    tick();
    check("rstm_late_done2", done_o, 1'b0);
    check("rstm_ready2", lsu_ready_o, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Multi-cycle load/store unit, parametrised successor to the single-cycle combinational LSU.
- Sits between the EXE stage and a request/grant/response data-memory bus.
- Handles byte/half/word loads and stores, variable memory latency and back-pressure, misaligned-access splitting (optional) and bus timeout.
- Holds the pipeline (ready low) while an access is in flight; returns writeback data with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, byte-address width of addr_i and dmem_addr.
- TIMEOUT_CYC, 64, cycles without gnt/rvalid before abort; 0 disables the timeout.
- RD_ADDR_W, 5, width of the destination register index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- lsu_valid_i  in  1  EXE presents an access this cycle.
- lsu_ready_o  out  1  LSU idle; an access is accepted when valid_i and ready_o are both high.
- addr_i  in  ADDR_W  byte address (ALU result).
- ld_cntr_i  in  3  000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU.
- st_cntr_i  in  2  00 no store, 01 SW, 10 SH, 11 SB; nonzero means store.
- wdata_i  in  32  store data, right-aligned.
- rd_addr_i  in  RD_ADDR_W  load destination register.
- dmem_req  out  1  bus request.
- dmem_gnt  in  1  bus accepts the request this cycle.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0).
- dmem_we  out  1  write.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted write data.
- dmem_rvalid  in  1  response for the oldest granted request; also acknowledges writes.
- dmem_rdata  in  32  read data.
- dmem_err  in  1  bus error, qualified by rvalid.
- done_o  out  1  one-cycle completion pulse.
- reg_write_o  out  1  done_o and the access was a load without error.
- rd_addr_o  out  RD_ADDR_W  destination register, valid with done_o.
- rdata_o  out  32  extended load data, valid with done_o.
- err_o  out  1  bus error, timeout or illegal ld_cntr; valid with done_o.
- misalign_o  out  1  access was misaligned; valid with done_o.

Behaviour:
- Reset: state IDLE; all outputs 0 except lsu_ready_o=1. Reset mid-access drops req immediately. Any rvalid arriving later in IDLE is ignored.
- States: IDLE, REQ, RESP, DONE. Beat counter is 1 bit; at most 2 beats per access.
- IDLE:
  - On accept, latch address, op, data and rd into registers; compute the beat count; go to REQ.
  - ld_cntr 101–111 on a load: no bus access; go to DONE with err=1.
- REQ: dmem_req=1 with address, we, be and wdata stable until gnt. On gnt go to RESP.
- RESP:
  - On rvalid, store rdata in the beat buffer; OR dmem_err into a sticky error.
  - If another beat remains, go to REQ with address +4.
  - Otherwise go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. lsu_ready_o is high only in IDLE.
- Minimum aligned latency: accept at T0, req+gnt at T1, rvalid at T2, done_o at T3.
- Store lanes:
  - off = addr[1:0]; base mask is 1111, 0011 or 0001 for SW, SH, SB.
  - 8-bit mask = base << off; 64-bit data = wdata << 8*off.
  - Beat 1 uses the low halves; beat 2 uses the high halves.
- Load:
  - Merge {beat2, beat1} >> 8*off, then extend per ld_cntr.
  - LH/LB sign-extend from bit 15/7; LHU/LBU zero-extend.
- Misaligned: a word at off≠0, or a half at off=3.
- Error handling: on error, rdata_o=0 and reg_write_o=0. A store is never retried.
- Timeout:
  - Counter resets on each state entry and on gnt/rvalid.
  - When it reaches TIMEOUT_CYC in REQ or RESP: drop req, go to DONE with err=1.
  - Late responses after a timeout are ignored until the next accept.
- Simultaneous: gnt and rvalid in the same cycle cannot occur for the same beat. rvalid in REQ is ignored.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses split into two beats as above; misalign_o=1 with a correct result.
- Undefined: misaligned access makes no bus request; goes straight IDLE→DONE; misalign_o=1, err_o=1, reg_write_o=0. Beat counter logic is removed.

Decomposition:
- Package lsu_pkg:
  - ld_cntr/st_cntr encodings.
  - State enum.
  - Base-mask function.
  - Sign/zero extend function.
- Sub-module lsu_lane_align (combinational): store mask/data shift and load merge/extend. The FSM stays in lsu_mc.

Test Plan:
- LW at 0x100, gnt at T1, rvalid at T2 with 0xDEADBEEF: dmem_be=1111, rdata_o=0xDEADBEEF at T3, reg_write_o=1.
- SB 0x000000A5 at 0x203, gnt delayed 3 cycles: dmem_addr=0x200, be=1000, wdata=0xA5000000, req held 3 cycles, done_o with reg_write_o=0.
- LH at 0x106 returning 0x80F0xxxx: rdata_o=0xFFFF80F0. LHU gives 0x000080F0.
- With split enabled, LW at 0x103 (beat1 0x11xxxxxx, beat2 0x00332211... at 0x104):
  - Two requests: 0x100 then 0x104.
  - rdata_o = {beat2[23:0], beat1[31:24]}; misalign_o=1.
  - Without the macro: no req, err_o=1.
- TIMEOUT_CYC=4, gnt never asserted: req drops after 4 cycles, done_o with err_o=1, ready_o high next cycle.
- rst asserted while in RESP: next cycle req=0, ready_o=1. A subsequent rvalid produces no done_o.
